// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_multi
// Brief    : N-channel push-button debouncer with press/release strobes and
//            optional auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_multi #(
    parameter int N_KEYS        = 4,
    parameter int CNT_W         = 16,
    parameter int STABLE_CNT    = 20000,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_FIRST  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              any_pressed
);

    localparam int c_REP_MAX = (REPEAT_FIRST > REPEAT_PERIOD) ? REPEAT_FIRST : REPEAT_PERIOD;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

    localparam logic [CNT_W-1:0]   c_STABLE_LAST   = CNT_W'(STABLE_CNT - 1);
    localparam logic [c_REP_W-1:0] c_REP_FIRST_LIM = c_REP_W'(REPEAT_FIRST);
    localparam logic [c_REP_W-1:0] c_REP_PER_LIM   = c_REP_W'(REPEAT_PERIOD);
    localparam logic               c_REL_LEVEL     = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    if (N_KEYS < 1) begin : g_bad_n_keys
        $error("key_debounce_multi: N_KEYS must be at least 1");
    end
    if (STABLE_CNT < 2 || longint'(STABLE_CNT) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_stable
        $error("key_debounce_multi: STABLE_CNT out of range 2..2^CNT_W-1");
    end
    if (REPEAT_FIRST < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
        $error("key_debounce_multi: REPEAT_FIRST and REPEAT_PERIOD must be >= 2");
    end

    logic [N_KEYS-1:0] w_level_nxt_all;
    logic              r_any;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
        logic               r_sync1;
        logic               r_sync2;
        logic               w_p;
        state_t             r_state;
        state_t             w_state_nxt;
        logic [CNT_W-1:0]   r_cnt;
        logic [CNT_W-1:0]   w_cnt_nxt;
        logic [c_REP_W-1:0] r_rcnt;
        logic [c_REP_W-1:0] w_rcnt_nxt;
        logic               r_later;
        logic               w_later_nxt;
        logic               r_level;
        logic               w_level_nxt;
        logic               r_press;
        logic               w_press_nxt;
        logic               r_rel;
        logic               w_rel_nxt;

        assign w_p = r_sync2 ^ c_REL_LEVEL;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sync1 <= c_REL_LEVEL;
                r_sync2 <= c_REL_LEVEL;
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_rcnt  <= '0;
                r_later <= 1'b0;
                r_level <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
            end else begin
                r_sync1 <= key_in[gi];
                r_sync2 <= r_sync1;
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_rcnt  <= w_rcnt_nxt;
                r_later <= w_later_nxt;
                r_level <= w_level_nxt;
                r_press <= w_press_nxt;
                r_rel   <= w_rel_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_rcnt_nxt  = r_rcnt;
            w_later_nxt = r_later;
            w_level_nxt = r_level;
            w_press_nxt = 1'b0;
            w_rel_nxt   = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_p) begin
                        w_state_nxt = ST_PRESS_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_p) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_STABLE_LAST) begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = '0;
                        w_rcnt_nxt  = '0;
                        w_later_nxt = 1'b0;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!w_p) begin
                        w_state_nxt = ST_RELEASE_WAIT;
                        w_cnt_nxt   = '0;
                    end else if (REPEAT_EN != 0) begin
                        // The reload cycle counts toward the interval, so pulses
                        // land LIMIT+1 cycles apart.
                        if (r_rcnt == (r_later ? c_REP_PER_LIM : c_REP_FIRST_LIM)) begin
                            w_rcnt_nxt  = '0;
                            w_later_nxt = 1'b1;
                            w_press_nxt = 1'b1;
                        end else begin
                            w_rcnt_nxt = r_rcnt + 1'b1;
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (w_p) begin
                        // Release glitch: resume the hold but keep the repeat phase.
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = '0;
                        w_rcnt_nxt  = '0;
                    end else if (r_cnt == c_STABLE_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b0;
                        w_rel_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_level_nxt_all[gi] = w_level_nxt;
        assign key_level[gi]       = r_level;
        assign key_press[gi]       = r_press;
        assign key_release[gi]     = r_rel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_level_nxt_all;
        end
    end

    assign any_pressed = r_any;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce_multi
// Brief    : Self-checking bench; one debouncer without and one with repeat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce_multi;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_a;
    logic [3:0] key_r;
    logic [3:0] level_a, press_a, rel_a;
    logic [3:0] level_r, press_r, rel_r;
    logic       any_a, any_r;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        int         dut;
        logic [3:0] press;
        logic [3:0] rel;
    } ev_t;
    ev_t sbq[$];

    typedef struct {
        logic [3:0] key;
        logic [3:0] level;
        logic       any;
    } vec_t;
    vec_t tbl[6];

    key_debounce_multi #(
        .N_KEYS(4), .CNT_W(16), .STABLE_CNT(4), .ACTIVE_LOW(1),
        .REPEAT_EN(0), .REPEAT_FIRST(8), .REPEAT_PERIOD(3)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .key_in(key_a), .key_level(level_a),
        .key_press(press_a), .key_release(rel_a), .any_pressed(any_a)
    );

    key_debounce_multi #(
        .N_KEYS(4), .CNT_W(16), .STABLE_CNT(4), .ACTIVE_LOW(1),
        .REPEAT_EN(1), .REPEAT_FIRST(8), .REPEAT_PERIOD(3)
    ) u_dut_r (
        .clk(clk), .rst_n(rst_n), .key_in(key_r), .key_level(level_r),
        .key_press(press_r), .key_release(rel_r), .any_pressed(any_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int at, input logic [3:0] p, input logic [3:0] r);
        ev_t e;
        e.cyc   = at;
        e.dut   = d;
        e.press = p;
        e.rel   = r;
        sbq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe monitor: every cycle, the strobes must equal the scheduled events.
    always @(negedge clk) begin : mon
        logic [3:0] ep0, er0, ep1, er1;
        ep0 = '0; er0 = '0; ep1 = '0; er1 = '0;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                if (sbq[i].dut == 0) begin
                    ep0 = ep0 | sbq[i].press;
                    er0 = er0 | sbq[i].rel;
                end else begin
                    ep1 = ep1 | sbq[i].press;
                    er1 = er1 | sbq[i].rel;
                end
                sbq.delete(i);
            end
        end
        check("press_a", 32'(press_a), 32'(ep0));
        check("release_a", 32'(rel_a), 32'(er0));
        check("press_r", 32'(press_r), 32'(ep1));
        check("release_r", 32'(rel_r), 32'(er1));
    end

    initial begin : stim
        int m;
        logic [3:0] prev;
        logic [3:0] pr;

        tbl[0] = '{key: 4'hA, level: 4'b0101, any: 1'b1};
        tbl[1] = '{key: 4'h5, level: 4'b1010, any: 1'b1};
        tbl[2] = '{key: 4'hF, level: 4'b0000, any: 1'b0};
        tbl[3] = '{key: 4'h6, level: 4'b1001, any: 1'b1};
        tbl[4] = '{key: 4'h7, level: 4'b1000, any: 1'b1};
        tbl[5] = '{key: 4'hF, level: 4'b0000, any: 1'b0};

        rst_n = 1'b0;
        key_a = 4'hF;
        key_r = 4'hF;
        tick(3);
        check("reset_level_a", 32'(level_a), 32'h0);
        check("reset_any_a", 32'(any_a), 32'h0);
        check("reset_level_r", 32'(level_r), 32'h0);
        check("reset_any_r", 32'(any_r), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Clean press on key 0: accepted 7 cycles after the edge.
        m = cyc;
        key_a = 4'hE;
        push(0, m + 7, 4'b0001, 4'b0000);
        tick(6);
        check("t1_level_early", 32'(level_a), 32'h0);
        tick(1);
        check("t1_level", 32'(level_a), 32'h1);
        check("t1_any", 32'(any_a), 32'h1);
        tick(5);

        // Release with a 2-cycle glitch inside RELEASE_WAIT, then clean release.
        key_a = 4'hF;
        tick(3);
        key_a = 4'hE;
        tick(2);
        m = cyc;
        key_a = 4'hF;
        push(0, m + 7, 4'b0000, 4'b0001);
        tick(6);
        check("t3_level_held", 32'(level_a), 32'h1);
        tick(1);
        check("t3_level_released", 32'(level_a), 32'h0);
        check("t3_any", 32'(any_a), 32'h0);
        tick(3);

        // Bounce on key 1: never stable long enough to be accepted.
        for (int i = 0; i < 5; i++) begin
            key_a = 4'hD;
            tick(2);
            key_a = 4'hF;
            tick(2);
        end
        tick(10);
        check("t2_bounce_level", 32'(level_a), 32'h0);

        // Multi-key patterns, including a simultaneous press of keys 0 and 3.
        prev = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            m = cyc;
            key_a = tbl[i].key;
            pr = ~tbl[i].key;
            if (pr != prev) push(0, m + 7, pr & ~prev, prev & ~pr);
            prev = pr;
            tick(10);
            check("vec_level", 32'(level_a), 32'(tbl[i].level));
            check("vec_any", 32'(any_a), 32'(tbl[i].any));
        end

        // Auto-repeat on key 2: acceptance, +9, then every 4 cycles.
        m = cyc;
        key_r = 4'hB;
        push(1, m + 7, 4'b0100, 4'b0000);
        for (int k = 0; k < 9; k++) push(1, m + 16 + 4 * k, 4'b0100, 4'b0000);
        tick(30);
        check("t4_level_hold", 32'(level_r), 32'h4);
        check("t4_any_hold", 32'(any_r), 32'h1);
        tick(17);
        key_r = 4'hF;
        push(1, cyc + 7, 4'b0000, 4'b0100);
        tick(6);
        check("t4_level_relwait", 32'(level_r), 32'h4);
        tick(1);
        check("t4_level_released", 32'(level_r), 32'h0);
        tick(5);

        // Reset while key 1 is held in PRESSED: no release, later re-acceptance.
        m = cyc;
        key_a = 4'hD;
        push(0, m + 7, 4'b0010, 4'b0000);
        tick(10);
        check("t6_level_before", 32'(level_a), 32'h2);
        rst_n = 1'b0;
        tick(1);
        check("t6_level_reset", 32'(level_a), 32'h0);
        check("t6_any_reset", 32'(any_a), 32'h0);
        rst_n = 1'b1;
        m = cyc;
        push(0, m + 7, 4'b0010, 4'b0000);
        tick(6);
        check("t6_level_wait", 32'(level_a), 32'h0);
        tick(1);
        check("t6_level_reaccept", 32'(level_a), 32'h2);
        check("t6_any_reaccept", 32'(any_a), 32'h1);
        key_a = 4'hF;
        push(0, cyc + 7, 4'b0000, 4'b0010);
        tick(12);
        check("t6_level_final", 32'(level_a), 32'h0);

        check("scoreboard_drain", 32'(sbq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
